// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Sequences single CPU load/store requests onto a word-wide synchronous
// data memory. Sub-word stores use a read-modify-write so that the other
// byte lanes of the word are preserved. Misaligned or illegal-size requests
// complete immediately with an error and never touch memory.
// Memory read data is valid the cycle after the word address is presented,
// so a read occupies RD (address out) and CAP (data back).
// All outputs come straight from registers; each one is computed from the
// next state so that it is valid in the same cycle as that state.
// ---------------------------------------------------------------------------
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [17:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_addr,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Illegal size, or an access that is not naturally aligned.
  function automatic logic is_err(input logic [1:0] size, input logic [1:0] off);
    logic e;
    case (size)
      SIZE_BYTE: e = 1'b0;
      SIZE_HALF: e = off[0];
      SIZE_WORD: e = (off != 2'b00);
      default:   e = 1'b1;
    endcase
    return e;
  endfunction

  // Pick the addressed little-endian lane out of a word and extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    if (off[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
      SIZE_HALF: r = {{16{sgn & h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of a word with right-justified store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          2'd3:    r[31:24] = wdata[7:0];
          default: r        = word;
        endcase
      end
      SIZE_HALF: begin
        if (off[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0]  = wdata[15:0];
        end
      end
      SIZE_WORD: r = wdata;
      default:   r = word;
    endcase
    return r;
  endfunction

  // Registers and their next-state values
  state_t      state_q,  state_d;
  logic        write_q,  write_d;
  logic [1:0]  size_q,   size_d;
  logic        signed_q, signed_d;
  logic [17:0] addr_q,   addr_d;
  logic [31:0] wdata_q,  wdata_d;
  logic        err_q,    err_d;
  logic        ready_q,  ready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q,  rdata_d;
  logic        rerr_q,   rerr_d;
  logic [15:0] maddr_q,  maddr_d;
  logic        mwe_q,    mwe_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic        accept_s;
  logic        busy_mem_s;

  // State, captured request and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 18'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rerr_q   <= 1'b0;
      maddr_q  <= 16'd0;
      mwe_q    <= 1'b0;
      mwdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      maddr_q  <= maddr_d;
      mwe_q    <= mwe_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Next-state, request capture and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = 32'd0;
    mwdata_d = 32'd0;
    accept_s = req_valid & (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = is_err(req_size, req_addr[1:0]);
          if (err_d) begin
            state_d = S_RESP;
          end else if (req_write && (req_size == SIZE_WORD)) begin
            // Full-word store needs no read; write the data as given.
            state_d  = S_WR;
            mwdata_d = req_wdata;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        // mem_read_data holds the addressed word during this state.
        if (write_q) begin
          state_d  = S_WR;
          mwdata_d = lane_merge(mem_read_data, wdata_q, size_q, addr_q[1:0]);
        end else begin
          state_d = S_RESP;
          rdata_d = lane_extract(mem_read_data, size_q, addr_q[1:0], signed_q);
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_mem_s = (state_d == S_RD) || (state_d == S_CAP) || (state_d == S_WR);
    ready_d    = (state_d == S_IDLE);
    rvalid_d   = (state_d == S_RESP);
    rerr_d     = (state_d == S_RESP) & err_d;
    mwe_d      = (state_d == S_WR);
    if (busy_mem_s) begin
      maddr_d = addr_d[17:2];
    end else begin
      maddr_d = 16'd0;
    end
  end

  assign req_ready      = ready_q;
  assign resp_valid     = rvalid_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = rerr_q;
  assign mem_addr       = maddr_q;
  assign mem_write_en   = mwe_q;
  assign mem_write_data = mwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for mem_access_unit. A behavioural memory image plus
// byte-mask arithmetic predicts each response when a request is accepted;
// a monitor checks responses as the DUT presents them. A small synchronous
// data memory model sits on the DUT memory port.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  mem_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          writes;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          writes_total = 0;
  int          writes_mark = 0;
  logic        mem_init;
  logic [31:0] mem_tb  [0:63];
  logic [31:0] ref_mem [0:63];

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous data memory: registered read, write on write_en
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_tb[i] <= 32'd0;
      mem_read_data <= 32'd0;
    end else begin
      mem_read_data <= mem_tb[mem_addr[5:0]];
      if (mem_write_en) begin
        mem_tb[mem_addr[5:0]] <= mem_write_data;
        writes_total <= writes_total + 1;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: predict the response of an accepted request
  task automatic model(input bit w, input bit [1:0] sz, input bit sg,
                       input bit [17:0] a, input bit [31:0] wd);
    exp_t   e;
    int     off;
    int     nbytes;
    longint word;
    longint mask;
    longint val;
    off    = int'(a) % 4;
    nbytes = 1 << sz;
    word   = longint'(ref_mem[a[7:2]]);
    e.acc  = cyc + 1;
    e.rdata = 32'd0;
    e.writes = 0;
    e.err  = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) ||
             (sz == 2'd2 && off != 0);
    if (e.err) begin
      e.lat = 0;
    end else begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      if (!w) begin
        e.lat = 2;
        val = (word >> (8 * off)) & mask;
        if (sg && nbytes < 4 && val >= (64'd1 << (8 * nbytes - 1)))
          val = val - (64'd1 << (8 * nbytes));
        e.rdata = val[31:0];
      end else begin
        e.writes = 1;
        e.lat = (sz == 2'd2) ? 1 : 3;
        val = (word & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
        ref_mem[a[7:2]] = val[31:0];
      end
    end
    sb.push_back(e);
  endtask

  // one cycle of stimulus, issued just after a falling edge
  task automatic drive(input bit v, input bit w, input bit [1:0] sz, input bit sg,
                       input bit [17:0] a, input bit [31:0] wd, input bit do_model,
                       output bit acc);
    req_valid  = v;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    acc = v && req_ready && !rst;
    if (acc && do_model) model(w, sz, sg, a, wd);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input bit w, input bit [1:0] sz, input bit sg,
                       input bit [17:0] a, input bit [31:0] wd);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) drive(1'b1, w, sz, sg, a, wd, 1'b1, acc);
    if (!acc) chk("accept_timeout", 0, 1);
    req_valid = 1'b0;
    drain();
    @(negedge clk);
  endtask

  // response monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_err", resp_err, e.err);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("latency", cyc - e.acc, e.lat);
        chk("write_count", writes_total - writes_mark, e.writes);
        chk("ready_in_resp", req_ready, 0);
        chk("mem_addr_in_resp", mem_addr, 0);
        writes_mark = writes_total;
      end
    end
  end

  initial begin
    bit acc;
    bit [1:0] sz;
    bit [17:0] a;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    rst = 1'b1;
    mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 18'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_write_en, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    rst = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);

    // word store then word load
    issue(1'b1, 2'd2, 1'b0, 18'h0C, 32'd1023);
    chk("mem_word3", mem_tb[3], 1023);
    issue(1'b0, 2'd2, 1'b0, 18'h0C, 32'd0);
    // sub-word loads with extension
    issue(1'b1, 2'd2, 1'b0, 18'h3C, 32'h80FF7F01);
    issue(1'b0, 2'd0, 1'b1, 18'h3D, 32'd0);
    issue(1'b0, 2'd0, 1'b1, 18'h3F, 32'd0);
    issue(1'b0, 2'd1, 1'b0, 18'h3E, 32'd0);
    issue(1'b0, 2'd1, 1'b1, 18'h3E, 32'd0);
    // byte read-modify-write
    issue(1'b1, 2'd2, 1'b0, 18'h10, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 18'h12, 32'hAA);
    chk("mem_word4_rmw", mem_tb[4], 32'h11AA3344);
    // errors
    issue(1'b0, 2'd1, 1'b0, 18'h01, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 18'h02, 32'h12345678);
    issue(1'b0, 2'd3, 1'b0, 18'h20, 32'd0);
    chk("mem_word0_after_err", mem_tb[0], 0);

    // reset while a sub-word store is in RD
    issue(1'b1, 2'd2, 1'b0, 18'h20, 32'hCAFEBABE);
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 18'h21, 32'h55, 1'b0, acc);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_mem_we", mem_write_en, 0);
    repeat (3) @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 18'h20, 32'd0);

    // reset coinciding with an accept drops the request
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 18'h24;
    req_wdata = 32'hDEADBEEF;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    chk("rst_accept_ready", req_ready, 1);
    repeat (5) @(negedge clk);

    // randomized traffic, then req_valid held high continuously
    for (int i = 0; i < 700; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 18'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((18'd1 << sz) - 18'd1);
      drive((i >= 400) || ($urandom_range(0, 3) != 0), 1'($urandom), sz,
            1'($urandom), a, $urandom, 1'b1, acc);
    end
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 64; i++) chk($sformatf("mem_final[%0d]", i), mem_tb[i], ref_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
